// File: rtl/uarch_pkg.sv
// Shared microarchitecture types and sizes for the execute/writeback slice.
// Holds the writeback packet format, the pipeline width and the writeback source indices.
package uarch_pkg;

  localparam int PIPE_WIDTH = 2;
  localparam int TAG_WIDTH  = 6;
  localparam int DATA_WIDTH = 32;

  localparam int NUM_WB_SRC = 5;
  localparam int WB_ALU0    = 0;
  localparam int WB_ALU1    = 1;
  localparam int WB_DMEM    = 2;
  localparam int WB_AGU     = 3;
  localparam int WB_MDU     = 4;

  typedef struct packed {
    logic                  is_valid;
    logic [TAG_WIDTH-1:0]  dest_tag;
    logic [DATA_WIDTH-1:0] data;
  } writeback_packet_t;

  // Distance of a tag from the ROB head; wraps modulo 2^TAG_WIDTH, smaller is older.
  function automatic logic [TAG_WIDTH-1:0] tag_age(input logic [TAG_WIDTH-1:0] tag,
                                                   input logic [TAG_WIDTH-1:0] head);
    return tag - head;
  endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// Per-source skid FIFO for writeback packets: circular storage, wrapping pointers, count.
// Ready depends only on the registered count, so a full FIFO stays not-ready even while popping.
module wb_skid_fifo
  import uarch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              i_push,
  input  writeback_packet_t i_pkt,
  input  logic              i_pop,
  output writeback_packet_t o_head,
  output logic              o_valid,
  output logic              o_rdy
);

  localparam int PTR_W = $clog2(DEPTH);

  writeback_packet_t  r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [PTR_W:0]     r_count;
  logic               w_push;
  logic               w_pop;

  assign o_rdy   = (r_count != (PTR_W + 1)'(DEPTH));
  assign o_valid = (r_count != '0);
  assign w_push  = i_push && o_rdy;
  assign w_pop   = i_pop && o_valid;
  assign o_head  = r_mem[r_head];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is left unreset on purpose; validity lives entirely in the count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= i_pkt;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Writeback arbiter: buffers results from every source and broadcasts the PIPE_WIDTH
// oldest FIFO heads (relative to the ROB head) onto the common data bus each cycle.
module cdb_arbiter
  import uarch_pkg::*;
#(
  parameter int NUM_WB_SRC = uarch_pkg::NUM_WB_SRC,
  parameter int SRC_DEPTH  = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  writeback_packet_t [NUM_WB_SRC-1:0]   src_pkts,
  output logic              [NUM_WB_SRC-1:0]   src_rdys,
  output writeback_packet_t [PIPE_WIDTH-1:0]   cdb_ports,
  input  logic              [TAG_WIDTH-1:0]    rob_head
);

  writeback_packet_t    w_heads      [NUM_WB_SRC];
  logic [TAG_WIDTH-1:0] w_age        [NUM_WB_SRC];
  logic [NUM_WB_SRC-1:0] w_head_valid;
  logic [NUM_WB_SRC-1:0] w_taken;

  for (genvar g = 0; g < NUM_WB_SRC; g++) begin : g_src
    wb_skid_fifo #(
      .DEPTH (SRC_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .i_push  (src_pkts[g].is_valid),
      .i_pkt   (src_pkts[g]),
      .i_pop   (w_taken[g]),
      .o_head  (w_heads[g]),
      .o_valid (w_head_valid[g]),
      .o_rdy   (src_rdys[g])
    );

    assign w_age[g] = tag_age(w_heads[g].dest_tag, rob_head);
  end

  // Repeated min-search: each slot takes the oldest head not claimed by an earlier slot.
  // The strict '<' over ascending indices resolves equal ages toward the lower source.
  always_comb begin
    logic                 w_found;
    int                   w_best;
    logic [TAG_WIDTH-1:0] w_best_age;
    // NOTE: every comb output is defaulted first so no path through the loops infers a latch.
    w_taken   = '0;
    cdb_ports = '0;
    for (int k = 0; k < PIPE_WIDTH; k++) begin
      w_found    = 1'b0;
      w_best     = 0;
      w_best_age = '0;
      for (int i = 0; i < NUM_WB_SRC; i++) begin
        if (w_head_valid[i] && !w_taken[i] && (!w_found || (w_age[i] < w_best_age))) begin
          w_found    = 1'b1;
          w_best     = i;
          w_best_age = w_age[i];
        end
      end
      if (w_found) begin
        cdb_ports[k]    = w_heads[w_best];
        w_taken[w_best] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus a scoreboard of
// expected broadcast packets, consumed in order as they appear on the bus.
module tb_cdb_arbiter;
  import uarch_pkg::*;

  localparam int NSRC = NUM_WB_SRC;

  logic                               clk = 1'b0;
  logic                               rst;
  logic                               flush;
  writeback_packet_t [NSRC-1:0]       src_pkts;
  logic              [NSRC-1:0]       src_rdys;
  writeback_packet_t [PIPE_WIDTH-1:0] cdb_ports;
  logic              [TAG_WIDTH-1:0]  rob_head;

  int n_checks = 0;
  int n_fail   = 0;
  bit sb_on    = 1'b0;
  writeback_packet_t sb_q [$];

  always #5 clk = ~clk;

  cdb_arbiter #(
    .NUM_WB_SRC (NSRC),
    .SRC_DEPTH  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .src_pkts  (src_pkts),
    .src_rdys  (src_rdys),
    .cdb_ports (cdb_ports),
    .rob_head  (rob_head)
  );

  task automatic clear_inputs();
    src_pkts = '0;
    flush    = 1'b0;
  endtask

  task automatic drive(input int src, input int tag, input int data);
    src_pkts[src].is_valid = 1'b1;
    src_pkts[src].dest_tag = TAG_WIDTH'(tag);
    src_pkts[src].data     = DATA_WIDTH'(data);
  endtask

  task automatic expect_pkt(input int tag, input int data);
    writeback_packet_t p;
    p.is_valid = 1'b1;
    p.dest_tag = TAG_WIDTH'(tag);
    p.data     = DATA_WIDTH'(data);
    sb_q.push_back(p);
  endtask

  // Compare every valid slot, in slot order, against the head of the scoreboard.
  task automatic score_slots();
    writeback_packet_t e;
    if (!sb_on) return;
    n_checks++;
    if (!cdb_ports[0].is_valid && cdb_ports[1].is_valid) begin
      n_fail++;
      $display("FAIL slot_order: slot1 valid (tag %0d) while slot0 invalid", cdb_ports[1].dest_tag);
    end
    for (int k = 0; k < PIPE_WIDTH; k++) begin
      if (cdb_ports[k].is_valid) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: slot%0d tag %0d data %0h, expected nothing",
                   k, cdb_ports[k].dest_tag, cdb_ports[k].data);
        end else begin
          e = sb_q.pop_front();
          if (cdb_ports[k] !== e) begin
            n_fail++;
            $display("FAIL sb_slot%0d: got tag %0d data %0h, expected tag %0d data %0h",
                     k, cdb_ports[k].dest_tag, cdb_ports[k].data, e.dest_tag, e.data);
          end
        end
      end
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    score_slots();
    @(posedge clk);
    #1;
  endtask

  task automatic check_sb_empty(input string name);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_leftover: %0d packets never broadcast, expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    rob_head = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cdb_ports !== '0) begin
      n_fail++;
      $display("FAIL reset_cdb: got %h expected 0", cdb_ports);
    end
    n_checks++;
    if (src_rdys !== 5'b11111) begin
      n_fail++;
      $display("FAIL reset_rdys: got %b expected 11111", src_rdys);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    sb_on = 1'b1;
    rob_head = 6'd0;
    drive(WB_ALU0, 5, 32'h55);
    expect_pkt(5, 32'h55);
    @(negedge clk);
    n_checks++;
    if (cdb_ports[0].is_valid !== 1'b0 || src_rdys !== 5'b11111) begin
      n_fail++;
      $display("FAIL single_n: slot0 valid %b rdys %b, expected 0 and 11111",
               cdb_ports[0].is_valid, src_rdys);
    end
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if (cdb_ports[0].is_valid !== 1'b1 || cdb_ports[0].dest_tag !== 6'd5 || src_rdys !== 5'b11111) begin
      n_fail++;
      $display("FAIL single_n1: slot0 valid %b tag %0d rdys %b, expected 1, 5, 11111",
               cdb_ports[0].is_valid, cdb_ports[0].dest_tag, src_rdys);
    end
    score_slots();
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (cdb_ports[0].is_valid !== 1'b0 || src_rdys !== 5'b11111) begin
      n_fail++;
      $display("FAIL single_n2: slot0 valid %b rdys %b, expected 0 and 11111",
               cdb_ports[0].is_valid, src_rdys);
    end
    @(posedge clk); #1;
    check_sb_empty("single");
  endtask

  task automatic test_wrap_age();
    rob_head = 6'd60;
    drive(WB_ALU0, 1, 32'hA0);
    drive(WB_ALU1, 62, 32'hA1);
    drive(WB_MDU, 63, 32'hA4);
    expect_pkt(62, 32'hA1);
    expect_pkt(63, 32'hA4);
    expect_pkt(1, 32'hA0);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if (cdb_ports[0].dest_tag !== 6'd62 || cdb_ports[1].dest_tag !== 6'd63 ||
        !cdb_ports[0].is_valid || !cdb_ports[1].is_valid) begin
      n_fail++;
      $display("FAIL wrap_first: got tags %0d,%0d expected 62,63", cdb_ports[0].dest_tag,
               cdb_ports[1].dest_tag);
    end
    score_slots();
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (cdb_ports[0].dest_tag !== 6'd1 || !cdb_ports[0].is_valid || cdb_ports[1].is_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_second: got tag %0d valid %b, slot1 valid %b, expected 1,1,0",
               cdb_ports[0].dest_tag, cdb_ports[0].is_valid, cdb_ports[1].is_valid);
    end
    score_slots();
    @(posedge clk); #1;
    next_cycle();
    check_sb_empty("wrap");
  endtask

  task automatic test_tie_break();
    rob_head = 6'd10;
    for (int c = 0; c < 5; c++) begin
      clear_inputs();
      if (c < 3) begin
        drive(WB_DMEM, 10 + c, WB_DMEM);
        drive(WB_AGU, 10 + c, WB_AGU);
        expect_pkt(10 + c, WB_DMEM);
        expect_pkt(10 + c, WB_AGU);
      end
      @(negedge clk);
      n_checks++;
      if (src_rdys !== 5'b11111) begin
        n_fail++;
        $display("FAIL tie_rdys c%0d: got %b expected 11111", c, src_rdys);
      end
      score_slots();
      @(posedge clk); #1;
    end
    clear_inputs();
    check_sb_empty("tie");
  endtask

  task automatic test_full_dequeue();
    rob_head = 6'd0;
    drive(WB_ALU0, 1, 32'hB0);
    drive(WB_ALU1, 2, 32'hB1);
    drive(WB_DMEM, 30, 32'hB2);
    expect_pkt(1, 32'hB0);
    expect_pkt(2, 32'hB1);
    expect_pkt(30, 32'hB2);
    expect_pkt(31, 32'hB3);
    expect_pkt(32, 32'hB4);
    next_cycle();
    clear_inputs();
    drive(WB_DMEM, 31, 32'hB3);
    next_cycle();
    clear_inputs();
    drive(WB_DMEM, 32, 32'hB4);
    @(negedge clk);
    n_checks++;
    if (src_rdys[WB_DMEM] !== 1'b0 || cdb_ports[0].dest_tag !== 6'd30 || !cdb_ports[0].is_valid) begin
      n_fail++;
      $display("FAIL full_deq: rdy %b slot0 tag %0d, expected 0 and 30",
               src_rdys[WB_DMEM], cdb_ports[0].dest_tag);
    end
    score_slots();
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (src_rdys[WB_DMEM] !== 1'b1) begin
      n_fail++;
      $display("FAIL full_accept: rdy %b expected 1", src_rdys[WB_DMEM]);
    end
    score_slots();
    @(posedge clk); #1;
    clear_inputs();
    for (int c = 0; c < 3; c++) next_cycle();
    check_sb_empty("full");
  endtask

  task automatic test_flush();
    sb_on = 1'b0;
    rob_head = 6'd0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < NSRC; i++) drive(i, 40 + i, i);
      if (c == 3) begin
        @(negedge clk);
        n_checks++;
        if (src_rdys !== 5'b00011) begin
          n_fail++;
          $display("FAIL flush_fill: rdys %b expected 00011", src_rdys);
        end
      end
      @(posedge clk); #1;
    end
    clear_inputs();
    flush = 1'b1;
    drive(WB_ALU0, 7, 32'h77);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if (cdb_ports !== '0 || src_rdys !== 5'b11111) begin
      n_fail++;
      $display("FAIL flush_next: cdb %h rdys %b expected 0 and 11111", cdb_ports, src_rdys);
    end
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (cdb_ports[0].is_valid !== 1'b0 || cdb_ports[1].is_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_stale c%0d: slot tags %0d/%0d valid, expected none",
                 c, cdb_ports[0].dest_tag, cdb_ports[1].dest_tag);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    sb_on = 1'b0;
    for (int c = 0; c < 8; c++) begin
      rob_head = TAG_WIDTH'($urandom);
      for (int i = 0; i < NSRC; i++) begin
        src_pkts[i].is_valid = 1'($urandom);
        src_pkts[i].dest_tag = TAG_WIDTH'($urandom);
        src_pkts[i].data     = $urandom;
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_inputs();
    rob_head = 6'd0;
    @(negedge clk);
    n_checks++;
    if (cdb_ports !== '0 || src_rdys !== 5'b11111) begin
      n_fail++;
      $display("FAIL rst_mid: cdb %h rdys %b expected 0 and 11111", cdb_ports, src_rdys);
    end
    @(posedge clk); #1;
    sb_on = 1'b1;
    drive(WB_ALU1, 9, 32'hC1);
    drive(WB_MDU, 8, 32'hC4);
    expect_pkt(8, 32'hC4);
    expect_pkt(9, 32'hC1);
    next_cycle();
    clear_inputs();
    for (int c = 0; c < 3; c++) next_cycle();
    check_sb_empty("rst_mid");
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap_age();
    test_tie_break();
    test_full_dequeue();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
